spi_slave_regfile: RTL

SPI mode-0 slave with an internal byte-wide register file, used as the device model on the far end of `spi_dpi`: it consumes `spi_clk_o`/`spi_mosi_o`/`spi_cs_o` and produces `spi_miso_i`. The SPI inputs are oversampled in the `sys_clk` domain; there is no logic clocked by SCLK. Each frame is a command byte followed by one or more data bytes. Register writes are also reported on a parallel strobe port for scoreboarding.

---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_sync_edge.sv | 62 ++++++
 rtl/spi_slave_regfile.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI register-file slave.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Frame state: waiting for CS, shifting the command byte, moving data bytes.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

  localparam int SPI_CMD_RD_BIT  = 7;
  localparam int SPI_ADDR_W      = 7;
  localparam int SPI_SYNC_STAGES = 2;

  // Burst address step: the last implemented register wraps to 0, anything
  // else (including out-of-range addresses) simply counts up.
  function automatic logic [SPI_ADDR_W-1:0] spi_addr_inc(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_ADDR_W:0]   depth
  );
    if ({1'b0, addr} == (depth - 8'd1)) begin
      return '0;
    end
    return addr + 7'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchronizer for one asynchronous input with
//               rise/fall pulse detection on the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES    = SPI_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  generate
    if (STAGES == 1) begin : g_single
      // Single capture flop.
      always_ff @(posedge clk) begin
        if (!rstb) begin
          r_sync <= {STAGES{RESET_VAL}};
        end else begin
          r_sync <= i_din;
        end
      end
    end else begin : g_multi
      // Shift the raw input through the synchronizer chain.
      always_ff @(posedge clk) begin
        if (!rstb) begin
          r_sync <= {STAGES{RESET_VAL}};
        end else begin
          r_sync <= {r_sync[STAGES-2:0], i_din};
        end
      end
    end
  endgenerate

  // Previous synchronized level, used for edge detection.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_prev <= RESET_VAL;
    end else begin
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_slave_regfile
// Description : SPI mode-0 slave with a byte-wide register file. SPI pins are
//               oversampled in the sys_clk domain. Frames are a command byte
//               (bit 7 = read, bits 6:0 = address) followed by data bytes.
//               Committed writes are reported on the wr_* strobe port.
// Options     : define SPI_SLAVE_AUTOINC_EN for burst address increment.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  rstb,
  input  logic                  spi_clk_i,
  input  logic                  spi_mosi_i,
  input  logic                  spi_cs_i,
  output logic                  spi_miso_o,
  output logic                  wr_valid_o,
  output logic [SPI_ADDR_W-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPI_ADDR_W:0] c_depth = DEPTH[SPI_ADDR_W:0];

  // --------------------------------------------------------------------------
  // Input capture
  // --------------------------------------------------------------------------
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
  logic w_cs_lvl,   w_cs_rise,   w_cs_fall;

  spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (sys_clk),
    .rstb    (rstb),
    .i_din   (spi_clk_i),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (sys_clk),
    .rstb    (rstb),
    .i_din   (spi_mosi_i),
    .o_level (w_mosi_lvl),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  // CS resets to the asserted level so that releasing reset in the middle of
  // a frame cannot fake a CS fall; the frame stays ignored until CS cycles.
  spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk     (sys_clk),
    .rstb    (rstb),
    .i_din   (spi_cs_i),
    .o_level (w_cs_lvl),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // Synchronizer outputs this block has no use for.
  logic w_unused;
  assign w_unused = &{1'b0, w_sclk_lvl, w_mosi_rise, w_mosi_fall, w_cs_lvl};

  // An SCLK edge coinciding with the CS fall is dropped.
  logic w_sclk_rise_ok, w_sclk_fall_ok;
  assign w_sclk_rise_ok = w_sclk_rise & ~w_cs_fall;
  assign w_sclk_fall_ok = w_sclk_fall & ~w_cs_fall;

  // --------------------------------------------------------------------------
  // Datapath state
  // --------------------------------------------------------------------------
  spi_state_e             r_state, w_state_nxt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift_in;
  logic [7:0]             r_shift_out;
  logic                   r_miso;
  logic [SPI_ADDR_W-1:0]  r_addr;
  logic                   r_rd;
  logic                   r_wr_pend;
  logic [SPI_ADDR_W-1:0]  r_wr_addr;
  logic [7:0]             r_wr_data;
  logic [7:0]             r_regs [DEPTH];

  logic [7:0]             w_mosi_byte;
  logic                   w_addr_ok;
  logic [7:0]             w_rd_byte;
  logic [SPI_ADDR_W-1:0]  w_addr_nxt;

  assign w_mosi_byte = {r_shift_in[6:0], w_mosi_lvl};
  assign w_addr_ok   = ({1'b0, r_addr} < c_depth);
  assign w_rd_byte   = w_addr_ok ? r_regs[r_addr[IDX_W-1:0]] : 8'h00;

`ifdef SPI_SLAVE_AUTOINC_EN
  assign w_addr_nxt  = spi_addr_inc(r_addr, c_depth);
`else
  assign w_addr_nxt  = r_addr;
`endif

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: CS rise always ends the frame, a CS fall always restarts it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
    end else if (w_cs_fall) begin
      w_state_nxt = ST_CMD;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_CMD: begin
          if (w_sclk_rise_ok && (r_bit_cnt == 3'd7)) begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: w_state_nxt = ST_DATA;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Bit shifting, command decode, read serialisation and write staging.
  always_ff @(posedge sys_clk) begin
    if (!rstb) begin
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_miso      <= 1'b0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_pend <= 1'b0;
      if (w_cs_rise || w_cs_fall) begin
        // Frame boundary: any partial byte is dropped here.
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          ST_CMD: begin
            if (w_sclk_rise_ok) begin
              r_shift_in <= w_mosi_byte;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr <= w_mosi_byte[SPI_ADDR_W-1:0];
                r_rd   <= w_mosi_byte[SPI_CMD_RD_BIT];
              end
            end
          end
          ST_DATA: begin
            if (r_rd) begin
              // Reads are driven on SCLK falls; the first fall of each byte
              // loads a fresh register value and presents its MSB.
              if (w_sclk_fall_ok) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd0) begin
                  r_miso      <= w_rd_byte[7];
                  r_shift_out <= {w_rd_byte[6:0], 1'b0};
                  r_addr      <= w_addr_nxt;
                end else begin
                  r_miso      <= r_shift_out[7];
                  r_shift_out <= {r_shift_out[6:0], 1'b0};
                end
              end
            end else if (w_sclk_rise_ok) begin
              r_shift_in <= w_mosi_byte;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                // Stage the completed byte; out-of-range writes vanish here.
                r_wr_pend <= w_addr_ok;
                r_wr_addr <= r_addr;
                r_wr_data <= w_mosi_byte;
                r_addr    <= w_addr_nxt;
              end
            end
          end
          default: r_miso <= 1'b0;
        endcase
      end
    end
  end

  // Commit staged writes to the register file and report them for one cycle.
  always_ff @(posedge sys_clk) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= 8'h00;
      end
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= 8'h00;
    end else begin
      wr_valid_o <= r_wr_pend;
      if (r_wr_pend) begin
        r_regs[r_wr_addr[IDX_W-1:0]] <= r_wr_data;
        wr_addr_o                    <= r_wr_addr;
        wr_data_o                    <= r_wr_data;
      end
    end
  end

  assign spi_miso_o = r_miso;

endmodule
`default_nettype wire
